// File: rtl/io_cond_pkg.sv
// Shared constants for the input conditioner: debounce default, reset level
// and the per-pin edge-select encoding.
package io_cond_pkg;

  localparam int unsigned DEB_CYCLES_DEF = 50000;
  localparam logic        RST_BIT_DEF    = 1'b0;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // Counter width that holds 0..cycles without wrapping.
  function automatic int unsigned deb_cnt_w(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/io_cond_bit.sv
// One conditioned pin: 2-flop synchroniser, debounce counter, stable level
// and registered edge pulses.
module io_cond_bit
  import io_cond_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic        RST_VAL    = RST_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned    CW       = deb_cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          diff_c;
  logic          take_c;

  assign diff_c = sync2 ^ stable;
  assign take_c = diff_c && (cnt == CNT_LAST);
  // Edge decisions one cycle early so the flag logic can set alongside the pulse.
  assign rise_c = take_c & sync2;
  assign fall_c = take_c & ~sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= RST_VAL;
      sync2  <= RST_VAL;
      stable <= RST_VAL;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      rise  <= rise_c;
      fall  <= fall_c;
      if (!diff_c || take_c) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (take_c) begin
        stable <= sync2;
      end
    end
  end

endmodule

// File: rtl/io_in_conditioner.sv
// Debounced input block with per-pin edge pulses and optional edge-flag
// interrupt logic, enabled by defining IO_IN_COND_IRQ_EN.
module io_in_conditioner
  import io_cond_pkg::*;
#(
  parameter int unsigned      WIDTH      = 4,
  parameter int unsigned      DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{RST_BIT_DEF}}
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  input  logic [WIDTH-1:0] irq_en_i,
  input  logic [WIDTH-1:0] irq_edge_i,
  input  logic [WIDTH-1:0] irq_clr_i,
  output logic [WIDTH-1:0] irq_flag_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] rise_c;
  logic [WIDTH-1:0] fall_c;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    io_cond_bit #(
      .DEB_CYCLES (DEB_CYCLES),
      .RST_VAL    (RST_VAL[g])
    ) u_bit (
      .clk    (mclk),
      .rst    (puc_rst),
      .pin    (pin_i[g]),
      .stable (stable_o[g]),
      .rise   (rise_o[g]),
      .fall   (fall_o[g]),
      .rise_c (rise_c[g]),
      .fall_c (fall_c[g])
    );
  end

`ifdef IO_IN_COND_IRQ_EN
  logic [WIDTH-1:0] flag_set_c;

  // Selected edge per pin, gated by enable.
  always_comb begin
    flag_set_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      flag_set_c[i] = irq_en_i[i] &
                      ((irq_edge_i[i] == EDGE_FALL) ? fall_c[i] : rise_c[i]);
    end
  end

  // Set has priority over clear; enable only masks the output.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      irq_flag_o <= '0;
    end else begin
      irq_flag_o <= (irq_flag_o & ~irq_clr_i) | flag_set_c;
    end
  end

  assign irq_o = |(irq_flag_o & irq_en_i);
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = ^{irq_en_i, irq_edge_i, irq_clr_i, rise_c, fall_c};
  assign irq_flag_o        = '0;
  assign irq_o             = 1'b0;
`endif

endmodule

// File: tb/tb_io_in_conditioner.sv
// Directed bench for io_in_conditioner (WIDTH=4, DEB_CYCLES=4, RST_VAL=0).
module tb_io_in_conditioner;
  import io_cond_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEB   = 4;
`ifdef IO_IN_COND_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic             mclk = 1'b0;
  logic             puc_rst;
  logic [WIDTH-1:0] pin_i;
  logic [WIDTH-1:0] stable_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic [WIDTH-1:0] irq_en_i;
  logic [WIDTH-1:0] irq_edge_i;
  logic [WIDTH-1:0] irq_clr_i;
  logic [WIDTH-1:0] irq_flag_o;
  logic             irq_o;

  int checks   = 0;
  int failures = 0;

  io_in_conditioner #(
    .WIDTH      (WIDTH),
    .DEB_CYCLES (DEB),
    .RST_VAL    (4'h0)
  ) dut (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
    .pin_i      (pin_i),
    .stable_o   (stable_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .irq_en_i   (irq_en_i),
    .irq_edge_i (irq_edge_i),
    .irq_clr_i  (irq_clr_i),
    .irq_flag_o (irq_flag_o),
    .irq_o      (irq_o)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic do_reset();
    puc_rst    = 1'b1;
    pin_i      = '0;
    irq_en_i   = '0;
    irq_edge_i = '0;
    irq_clr_i  = '0;
    tick();
    tick();
    puc_rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] es, er, ef;
    puc_rst    = 1'b1;
    pin_i      = 4'hF;
    irq_en_i   = '0;
    irq_edge_i = '0;
    irq_clr_i  = '0;
    for (int r = 0; r < 3; r++) begin
      tick();
      checks++;
      if ({stable_o, rise_o, fall_o, irq_flag_o, irq_o} !== 17'h0) begin
        failures++;
        $display("FAIL reset.hold r=%0d got s=%h r=%h f=%h fl=%h irq=%b exp all 0",
                 r, stable_o, rise_o, fall_o, irq_flag_o, irq_o);
      end
    end
    puc_rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      es = (k >= 6) ? 4'hF : 4'h0;
      er = (k == 6) ? 4'hF : 4'h0;
      checks++;
      if (stable_o !== es || rise_o !== er || fall_o !== 4'h0) begin
        failures++;
        $display("FAIL reset.release k=%0d got s=%h r=%h f=%h exp s=%h r=%h f=0",
                 k, stable_o, rise_o, fall_o, es, er);
      end
    end
    pin_i = 4'h0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      es = (k >= 6) ? 4'h0 : 4'hF;
      ef = (k == 6) ? 4'hF : 4'h0;
      checks++;
      if (stable_o !== es || fall_o !== ef || rise_o !== 4'h0) begin
        failures++;
        $display("FAIL reset.allfall k=%0d got s=%h r=%h f=%h exp s=%h r=0 f=%h",
                 k, stable_o, rise_o, fall_o, es, ef);
      end
    end
  endtask

  task automatic test_rise();
    logic [WIDTH-1:0] es, er;
    do_reset();
    pin_i[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      es = (k >= 6) ? 4'h1 : 4'h0;
      er = (k == 6) ? 4'h1 : 4'h0;
      checks++;
      if (stable_o !== es || rise_o !== er || fall_o !== 4'h0) begin
        failures++;
        $display("FAIL rise k=%0d got s=%h r=%h f=%h exp s=%h r=%h f=0",
                 k, stable_o, rise_o, fall_o, es, er);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    pin_i[1] = 1'b1;
    repeat (3) tick();
    pin_i[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (stable_o !== 4'h0 || rise_o !== 4'h0 || fall_o !== 4'h0) begin
        failures++;
        $display("FAIL glitch k=%0d got s=%h r=%h f=%h exp all 0",
                 k, stable_o, rise_o, fall_o);
      end
    end
  endtask

  task automatic test_min_pulse();
    logic [WIDTH-1:0] es, er, ef;
    do_reset();
    pin_i[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) pin_i[1] = 1'b0;
      es = (k >= 6 && k < 10) ? 4'h2 : 4'h0;
      er = (k == 6) ? 4'h2 : 4'h0;
      ef = (k == 10) ? 4'h2 : 4'h0;
      checks++;
      if (stable_o !== es || rise_o !== er || fall_o !== ef) begin
        failures++;
        $display("FAIL min_pulse k=%0d got s=%h r=%h f=%h exp s=%h r=%h f=%h",
                 k, stable_o, rise_o, fall_o, es, er, ef);
      end
    end
  endtask

  task automatic test_irq_fall();
    logic [WIDTH-1:0] ef, efl;
    logic             ei;
    do_reset();
    irq_en_i[2]   = 1'b1;
    irq_edge_i[2] = EDGE_FALL;
    pin_i[2]      = 1'b1;
    repeat (8) tick();
    checks++;
    if (stable_o !== 4'h4 || irq_flag_o !== 4'h0 || irq_o !== 1'b0) begin
      failures++;
      $display("FAIL irq.pre got s=%h fl=%h irq=%b exp s=4 fl=0 irq=0",
               stable_o, irq_flag_o, irq_o);
    end
    pin_i[2] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 5) irq_clr_i[2] = 1'b1;
      if (k == 7) irq_clr_i[2] = 1'b0;
      ef  = (k == 6) ? 4'h4 : 4'h0;
      efl = (k == 6) ? (IRQ_ON ? 4'h4 : 4'h0) : 4'h0;
      ei  = (k == 6) ? IRQ_ON : 1'b0;
      checks++;
      if (fall_o !== ef || irq_flag_o !== efl || irq_o !== ei) begin
        failures++;
        $display("FAIL irq.fall k=%0d got f=%h fl=%h irq=%b exp f=%h fl=%h irq=%b",
                 k, fall_o, irq_flag_o, irq_o, ef, efl, ei);
      end
    end
  endtask

  task automatic test_irq_mask();
    logic [WIDTH-1:0] efl;
    do_reset();
    irq_en_i[2]   = 1'b1;
    irq_edge_i[2] = EDGE_RISE;
    irq_edge_i[3] = EDGE_FALL;
    irq_en_i[3]   = 1'b1;
    pin_i[2]      = 1'b1;
    pin_i[3]      = 1'b1;
    efl = IRQ_ON ? 4'h4 : 4'h0;
    repeat (6) tick();
    checks++;
    if (rise_o !== 4'hC || irq_flag_o !== efl || irq_o !== IRQ_ON) begin
      failures++;
      $display("FAIL mask.set got r=%h fl=%h irq=%b exp r=c fl=%h irq=%b",
               rise_o, irq_flag_o, irq_o, efl, IRQ_ON);
    end
    irq_en_i[2] = 1'b0;
    #1;
    checks++;
    if (irq_o !== 1'b0 || irq_flag_o !== efl) begin
      failures++;
      $display("FAIL mask.off got fl=%h irq=%b exp fl=%h irq=0", irq_flag_o, irq_o, efl);
    end
    tick();
    checks++;
    if (irq_o !== 1'b0 || irq_flag_o !== efl) begin
      failures++;
      $display("FAIL mask.hold got fl=%h irq=%b exp fl=%h irq=0", irq_flag_o, irq_o, efl);
    end
    irq_en_i[2] = 1'b1;
    #1;
    checks++;
    if (irq_o !== IRQ_ON) begin
      failures++;
      $display("FAIL mask.unmask got irq=%b exp %b", irq_o, IRQ_ON);
    end
    irq_clr_i[2] = 1'b1;
    tick();
    irq_clr_i[2] = 1'b0;
    checks++;
    if (irq_flag_o !== 4'h0 || irq_o !== 1'b0) begin
      failures++;
      $display("FAIL mask.clr got fl=%h irq=%b exp fl=0 irq=0", irq_flag_o, irq_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] es, er;
    do_reset();
    pin_i[3] = 1'b1;
    repeat (4) tick();
    puc_rst = 1'b1;
    tick();
    puc_rst = 1'b0;
    checks++;
    if (stable_o !== 4'h0 || rise_o !== 4'h0 || fall_o !== 4'h0) begin
      failures++;
      $display("FAIL rstmid.rst got s=%h r=%h f=%h exp all 0", stable_o, rise_o, fall_o);
    end
    for (int k = 1; k <= 7; k++) begin
      tick();
      es = (k >= 6) ? 4'h8 : 4'h0;
      er = (k == 6) ? 4'h8 : 4'h0;
      checks++;
      if (stable_o !== es || rise_o !== er || fall_o !== 4'h0) begin
        failures++;
        $display("FAIL rstmid k=%0d got s=%h r=%h f=%h exp s=%h r=%h f=0",
                 k, stable_o, rise_o, fall_o, es, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_min_pulse();
    test_irq_fall();
    test_irq_mask();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_in_conditioner.md
IO_IN_CONDITIONER -- requirements
Module: io_in_conditioner

Interface
REQ-001 Parameter WIDTH, default 4: number of input pins conditioned.
REQ-002 Parameter DEB_CYCLES, default 50000: stable-level cycles required before accepting a change (1 ms at 50 MHz); legal range >= 1.
REQ-003 Parameter RST_VAL, default {WIDTH{1'b0}}: reset level of the synchroniser and stable registers.
REQ-004 mclk  in  1  the single clock; all state updates on its rising edge.
REQ-005 puc_rst  in  1  synchronous, active-high reset.
REQ-006 pin_i  in  WIDTH  raw pad levels from the input buffer outputs; asynchronous to mclk.
REQ-007 stable_o  out  WIDTH  debounced level per pin.
REQ-008 rise_o  out  WIDTH  one-cycle pulse when stable_o goes 0->1.
REQ-009 fall_o  out  WIDTH  one-cycle pulse when stable_o goes 1->0.
REQ-010 irq_en_i  in  WIDTH  per-pin interrupt enable.
REQ-011 irq_edge_i  in  WIDTH  per-pin edge select: 0 = rising, 1 = falling.
REQ-012 irq_clr_i  in  WIDTH  per-pin flag clear, level-sampled each cycle.
REQ-013 irq_flag_o  out  WIDTH  per-pin latched edge flag.
REQ-014 irq_o  out  1  OR of (irq_flag_o & irq_en_i).

Function
REQ-015 Each pin SHALL pass through a 2-flop synchroniser (sync1, sync2); sync2 is the only internal view of the pin.
REQ-016 Per pin, the counter SHALL clear to 0 whenever sync2 equals stable.
REQ-017 While sync2 differs from stable and the counter is below DEB_CYCLES-1, the counter SHALL increment by 1.
REQ-018 When sync2 differs from stable and the counter equals DEB_CYCLES-1, stable SHALL take sync2 and the counter SHALL clear, in the same cycle.
REQ-019 Latency: a clean pin change at edge N SHALL appear on stable_o at edge N+2+DEB_CYCLES.
REQ-020 A pulse of sync2 shorter than DEB_CYCLES cycles SHALL NOT change stable_o and SHALL restart the count from 0.
REQ-021 Counter width SHALL be $clog2(DEB_CYCLES+1) bits. The counter SHALL never wrap.
REQ-022 rise_o/fall_o SHALL be registered and asserted exactly in the cycle stable_o first shows the new value.
REQ-023 A flag SHALL set when irq_en_i=1 and the selected edge pulse occurs.
REQ-024 A flag SHALL clear when irq_clr_i=1.
REQ-025 When set and clear coincide, set SHALL win.
REQ-026 Deasserting irq_en_i SHALL mask irq_o but SHALL NOT clear the flag.
REQ-027 Pins SHALL be fully independent; simultaneous events on several pins SHALL each be handled in the same cycle.

Reset
REQ-028 On puc_rst=1 at a clock edge, the following SHALL load RST_VAL: sync1, sync2, stable_o.
REQ-029 On puc_rst=1 at a clock edge, the following SHALL load 0: counters, rise_o, fall_o, irq_flag_o.
REQ-030 Reset asserted mid-count SHALL abandon the count. No pulse SHALL be generated for the abandoned transition.
REQ-031 puc_rst SHALL override every other input in the cycle it is sampled.

Configuration
REQ-032 Macro IO_IN_COND_IRQ_EN defined: the flag and irq logic of REQ-023..026 SHALL be present.
REQ-033 Macro absent: irq_flag_o and irq_o SHALL be tied to 0, with no flag registers, and irq_en_i/irq_edge_i/irq_clr_i ignored; all other behaviour SHALL be unchanged.

Structure
REQ-034 A shared package io_cond_pkg SHALL hold the DEB_CYCLES default, the RST_VAL default and the edge-select encoding constants (EDGE_RISE=0, EDGE_FALL=1).
REQ-035 The per-pin synchroniser, counter and stable register SHALL be sub-module io_cond_bit, instantiated WIDTH times.
REQ-036 The flag and irq logic SHALL remain in the top module.

Verification (WIDTH=4, DEB_CYCLES=4, RST_VAL=0, macro defined unless stated)
REQ-037 Reset held 3 cycles with pin_i=4'hF -> all outputs 0 during reset; stable_o=4'hF exactly 6 cycles after release; rise_o=4'hF for 1 cycle at that moment.
REQ-038 pin_i[0] 0->1 at edge N and held -> stable_o[0]=1 at edge N+6; rise_o[0]=1 only at edge N+6; fall_o=0 throughout.
REQ-039 pin_i[1] high for 3 cycles then low -> stable_o[1] stays 0; no rise_o/fall_o pulses.
REQ-040 irq_en_i[2]=1, irq_edge_i[2]=1, pin_i[2] stable 1 then 0 -> irq_flag_o[2]=1 and irq_o=1 on the fall_o[2] cycle; irq_clr_i[2] in that same cycle -> flag stays 1; clr next cycle -> flag 0, irq_o 0.
REQ-041 puc_rst pulsed while pin_i[3]'s counter=2 -> stable_o[3]=0, no pulse; the count restarts after release.
REQ-042 Macro undefined, run REQ-040 stimulus -> irq_o and irq_flag_o stay 0; stable_o/fall_o identical to the defined build.
